// File: rtl/fetch1.sv
// Fetch stage 1: owns the fetch PC and drives the address for a two-word fetch pair.
// A direct-mapped BTB with 2-bit counters picks the next PC. Per-slot prediction flags are registered to line up with idata.
module fetch1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BTB_IDX  = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        frontend_we_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_slot_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  output logic [31:0] iaddr_o,
  output logic [31:0] pc_o,
  output logic        pred_0_o,
  output logic        pred_1_o,
  output logic        zero_1_o
);

  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = 30 - BTB_IDX;

  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic              btb_slot   [ENTRIES];
  logic [31:0]       btb_target [ENTRIES];
  logic [1:0]        btb_ctr    [ENTRIES];

  logic [31:0]        pc_q;
  logic [31:0]        pc_nxt;
  logic [BTB_IDX-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic               lk_taken;
  logic               lk_slot;

  logic [BTB_IDX-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic [1:0]         up_ctr_nxt;
  logic               unused_upd_lsb;

  assign unused_upd_lsb = ^upd_pc_i[1:0];

  // Lookup reads the table before any same-cycle update lands.
  assign lk_idx   = pc_q[BTB_IDX+1:2];
  assign lk_tag   = pc_q[31:BTB_IDX+2];
  assign lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && btb_ctr[lk_idx][1];
  assign lk_slot  = btb_slot[lk_idx];

  assign up_idx = upd_pc_i[BTB_IDX+1:2];
  assign up_tag = upd_pc_i[31:BTB_IDX+2];
  assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag) &&
                  (btb_slot[up_idx] == upd_slot_i);

  always_comb begin
    up_ctr_nxt = btb_ctr[up_idx];
    if (upd_taken_i && (btb_ctr[up_idx] != 2'b11)) begin
      up_ctr_nxt = btb_ctr[up_idx] + 2'd1;
    end else if (!upd_taken_i && (btb_ctr[up_idx] != 2'b00)) begin
      up_ctr_nxt = btb_ctr[up_idx] - 2'd1;
    end
  end

  always_comb begin
    pc_nxt = pc_q;
    if (redirect_i) begin
      pc_nxt = redirect_pc_i;
    end else if (frontend_we_i) begin
      pc_nxt = lk_taken ? btb_target[lk_idx] : pc_q + 32'd8;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (upd_valid_i && !up_hit && upd_taken_i) begin
      btb_valid[up_idx] <= 1'b1;
    end
  end

  // Payload fields need no reset; an entry is only trusted through its valid bit.
  always_ff @(posedge clock_i) begin
    if (!reset_i && upd_valid_i) begin
      if (up_hit) begin
        btb_ctr[up_idx] <= up_ctr_nxt;
        if (upd_taken_i) begin
          btb_target[up_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        btb_tag[up_idx]    <= up_tag;
        btb_slot[up_idx]   <= upd_slot_i;
        btb_target[up_idx] <= upd_target_i;
        btb_ctr[up_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q     <= RESET_PC;
      pc_o     <= RESET_PC;
      pred_0_o <= 1'b0;
      pred_1_o <= 1'b0;
      zero_1_o <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (frontend_we_i) begin
        pc_o <= pc_q;
      end
      // The pair in flight during a redirect is flushed downstream, so it carries no prediction.
      if (redirect_i) begin
        pred_0_o <= 1'b0;
        pred_1_o <= 1'b0;
        zero_1_o <= 1'b0;
      end else if (frontend_we_i) begin
        pred_0_o <= lk_taken && !lk_slot;
        pred_1_o <= lk_taken && lk_slot;
        zero_1_o <= lk_taken && !lk_slot;
      end
    end
  end

  assign iaddr_o = pc_q;

endmodule
